systolic_run_ctrl: RTL and testbench

- Sequences one matrix-multiply pass of the DIM x DIM systolic array inside the TPU memory-mapped block.
- Decodes the host "start" write at START_ADDR and drives the shift enables of the skewed A/B operand buffers and the array compute enable for exactly the required number of cycles.
- Blocks host access to the A/B/C regions while a pass is in flight, then reports completion.

---
 rtl/systolic_run_ctrl.sv | 99 +++++++++
 tb/tb_systolic_run_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/systolic_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_run_ctrl
// Purpose  : Sequences one DIM x DIM systolic matrix-multiply pass launched by
//            a host write, gating A/B skew shifts and array compute enables.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_run_ctrl #(
    parameter int               DIM        = 8,
    parameter int               ADDRW      = 16,
    parameter int               MEM_LAT    = 1,
    parameter logic [ADDRW-1:0] START_ADDR = 16'h0400,
    parameter logic [ADDRW-1:0] PROT_LO    = 16'h0100,
    parameter logic [ADDRW-1:0] PROT_HI    = 16'h03FF,
    localparam int              CNT_W      = $clog2(3*DIM+MEM_LAT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             host_req,
    input  logic             host_we,
    input  logic [ADDRW-1:0] host_addr,
    output logic             host_gnt,
    input  logic             stall,
    output logic             mem_en,
    output logic             sa_en,
    output logic             busy,
    output logic             done,
    output logic             start_err,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // Operand stream length includes the skew; the run adds the buffer latency.
    localparam logic [CNT_W-1:0] c_L      = CNT_W'(3*DIM-2);
    localparam logic [CNT_W-1:0] c_T_LAST = CNT_W'(3*DIM-2+MEM_LAT-1);
    localparam logic [CNT_W-1:0] c_LAT    = CNT_W'(MEM_LAT);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_start_err;

    logic w_start;
    logic w_prot;
    logic w_run;

    assign w_start   = host_req & host_we & (host_addr == START_ADDR);
    assign w_prot    = (host_addr >= PROT_LO) && (host_addr <= PROT_HI);
    assign w_run     = (r_state == c_RUN);
    assign busy      = (r_state == c_RUN) | (r_state == c_DONE);
    assign done      = (r_state == c_DONE);
    assign host_gnt  = host_req & ~(busy & w_prot);
    assign mem_en    = w_run & ~stall & (r_cnt < c_L);
    assign sa_en     = w_run & ~stall & (r_cnt >= c_LAT);
    assign start_err = r_start_err;
    assign cnt       = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_start_err <= 1'b0;
        end else begin
            if (w_start && busy) begin
                r_start_err <= 1'b1;
            end
            case (r_state)
                c_IDLE: begin
                    if (w_start) begin
                        r_state <= c_RUN;
                        r_cnt   <= '0;
                    end
                end
                c_RUN: begin
                    // Counter stops at the last index instead of wrapping.
                    if (!stall) begin
                        if (r_cnt == c_T_LAST) begin
                            r_state <= c_DONE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_run_ctrl
// Purpose  : Directed and random stimulus for systolic_run_ctrl against a
//            pass-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_run_ctrl;

    localparam int DIM     = 8;
    localparam int MEM_LAT = 1;
    localparam int L       = 3*DIM-2;
    localparam int T       = L+MEM_LAT;
    localparam int CNT_W   = $clog2(3*DIM+MEM_LAT);

    logic             clk = 1'b1;
    logic             rst = 1'b1;
    logic             host_req = 1'b0;
    logic             host_we = 1'b0;
    logic [15:0]      host_addr = 16'h0000;
    logic             stall = 1'b0;
    logic             host_gnt, mem_en, sa_en, busy, done, start_err;
    logic [CNT_W-1:0] cnt;

    int  n_vec = 0;
    int  n_err = 0;
    bit  chk_en = 1'b0;
    bit  last_done;

    // Reference model: a pass is active for T unstalled run cycles plus one done cycle.
    bit  m_active = 1'b0;
    int  m_pos    = 0;
    bit  m_err    = 1'b0;

    systolic_run_ctrl #(.DIM(DIM), .ADDRW(16), .MEM_LAT(MEM_LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .host_req (host_req),
        .host_we  (host_we),
        .host_addr(host_addr),
        .host_gnt (host_gnt),
        .stall    (stall),
        .mem_en   (mem_en),
        .sa_en    (sa_en),
        .busy     (busy),
        .done     (done),
        .start_err(start_err),
        .cnt      (cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit req, input bit we, input logic [15:0] addr, input bit st);
        rst = r; host_req = req; host_we = we; host_addr = addr; stall = st;
    endtask

    task automatic tick();
        bit run, prot;
        @(negedge clk);
        if (chk_en) begin
            run  = m_active && (m_pos < T);
            prot = (host_addr >= 16'h0100) && (host_addr <= 16'h03FF);
            check_val("host_gnt", 32'(host_gnt), 32'(host_req && !(m_active && prot)));
            check_val("busy", 32'(busy), 32'(m_active));
            check_val("done", 32'(done), 32'(m_active && m_pos == T));
            check_val("mem_en", 32'(mem_en), 32'(run && !stall && m_pos < L));
            check_val("sa_en", 32'(sa_en), 32'(run && !stall && m_pos >= MEM_LAT));
            check_val("start_err", 32'(start_err), 32'(m_err));
            if (run) check_val("cnt", 32'(cnt), 32'(m_pos));
        end
        last_done = done;
        @(posedge clk);
        if (rst) begin
            m_active = 1'b0; m_pos = 0; m_err = 1'b0;
        end else begin
            bit start;
            start = host_req && host_we && (host_addr == 16'h0400);
            if (!m_active) begin
                if (start) begin m_active = 1'b1; m_pos = 0; end
            end else begin
                if (start) m_err = 1'b1;
                if (m_pos == T) m_active = 1'b0;
                else if (!stall) m_pos++;
            end
        end
        #1;
    endtask

    // One pass: start in this cycle, then per-cycle stimulus keyed by cycles since start.
    task automatic run_pass(input int st_lo, input int st_hi, input int err_at, input int rst_at, output int lat);
        logic [15:0] probe [4];
        bit          probe_we [4];
        probe[0] = 16'h0300; probe_we[0] = 1'b0;
        probe[1] = 16'h0180; probe_we[1] = 1'b1;
        probe[2] = 16'h0000; probe_we[2] = 1'b0;
        probe[3] = 16'h0500; probe_we[3] = 1'b0;
        drive(0, 1, 1, 16'h0400, 0);
        tick();
        lat = 0;
        do begin
            lat++;
            if (lat == rst_at)                   drive(1, 0, 0, 16'h0000, 0);
            else if (lat == err_at)              drive(0, 1, 1, 16'h0400, 0);
            else if (lat >= st_lo && lat <= st_hi) drive(0, 0, 0, 16'h0000, 1);
            else if (lat >= 2 && lat <= 5)       drive(0, 1, probe_we[lat-2], probe[lat-2], 0);
            else                                 drive(0, 0, 0, 16'h0000, 0);
            tick();
        end while (!last_done && lat != rst_at && lat < 60);
        drive(0, 0, 0, 16'h0000, 0);
    endtask

    initial begin
        int lat;
        drive(1, 0, 0, 16'h0000, 0);
        tick();
        chk_en = 1'b1;
        tick();
        drive(0, 0, 0, 16'h0000, 0);
        check_val("reset_cnt", 32'(cnt), 32'd0);
        for (int i = 0; i < 10; i++) tick();

        run_pass(0, -1, 0, 0, lat);
        check_val("done_lat_plain", 32'(lat), 32'd24);
        drive(0, 1, 0, 16'h0300, 0);
        tick();

        run_pass(11, 15, 0, 0, lat);
        check_val("done_lat_stall", 32'(lat), 32'd29);

        run_pass(0, -1, 8, 0, lat);
        check_val("done_lat_restart", 32'(lat), 32'd24);
        drive(0, 0, 0, 16'h0000, 0);
        for (int i = 0; i < 3; i++) tick();
        check_val("err_sticky", 32'(start_err), 32'd1);

        run_pass(0, -1, 0, 16, lat);
        check_val("rst_mid_pass", 32'(lat), 32'd16);
        tick();
        run_pass(0, -1, 0, 0, lat);
        check_val("done_lat_after_rst", 32'(lat), 32'd24);

        // Back-to-back: start in the idle cycle right after done.
        run_pass(0, -1, 0, 0, lat);
        check_val("done_lat_b2b", 32'(lat), 32'd24);

        for (int i = 0; i < 3000; i++) begin
            logic [15:0] a;
            case ($urandom_range(5))
                0:       a = 16'h0400;
                1:       a = 16'h0100;
                2:       a = 16'h03FF;
                3:       a = 16'h00FF;
                4:       a = 16'h0400 + 16'($urandom_range(1));
                default: a = 16'($urandom);
            endcase
            drive($urandom_range(199) == 0, 1'($urandom), 1'($urandom), a, $urandom_range(3) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
